// File: rtl/serial_tx_fifo.sv
// Serial transmitter with a DEPTH-word input FIFO. Words enter through a valid/ready
// handshake and leave on Dout one bit per Div+1 cycles, in the bit order latched at pop.
module serial_tx_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int DIVW  = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DW-1:0]            InData,
  input  logic                     MsbFirst,
  input  logic [DIVW-1:0]          Div,
  input  logic                     Flush,
  output logic                     Dout,
  output logic                     TxBusy,
  output logic                     TxDone,
  output logic [$clog2(DEPTH):0]   Level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(DW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  state_t          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            msb_q, msb_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] divcnt_q, divcnt_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic            dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [PW-1:0]   level_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic [DW-1:0]   head_s;
  logic [DW-1:0]   shnext_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_s  = wr_ptr_q - rd_ptr_q;
  assign full_s   = (level_s == PW'(DEPTH));
  assign empty_s  = (level_s == {PW{1'b0}});
  assign push_s   = InValid && !full_s && !Flush;
  assign head_s   = mem_q[rd_ptr_q[AW-1:0]];
  assign shnext_s = msb_q ? {shreg_q[DW-2:0], 1'b0} : {1'b0, shreg_q[DW-1:1]};

  assign InReady = !full_s;
  assign Level   = level_s;
  assign Dout    = dout_q;
  assign TxBusy  = busy_q;
  assign TxDone  = done_q;

  // FIFO storage write port; contents need no reset since pointers gate every read.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= InData;
    end
  end

  // Next-state logic for pointers, transmit FSM and registered outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    shreg_d  = shreg_q;
    msb_d    = msb_q;
    div_d    = div_q;
    divcnt_d = divcnt_q;
    bitcnt_d = bitcnt_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (Flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      state_d  = ST_IDLE;
      divcnt_d = {DIVW{1'b0}};
      bitcnt_d = {BW{1'b0}};
      dout_d   = 1'b0;
      busy_d   = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (!empty_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            shreg_d  = head_s;
            msb_d    = MsbFirst;
            div_d    = Div;
            dout_d   = MsbFirst ? head_s[DW-1] : head_s[0];
            bitcnt_d = {BW{1'b0}};
            divcnt_d = {DIVW{1'b0}};
            busy_d   = 1'b1;
            state_d  = ST_SHIFT;
          end else begin
            dout_d = 1'b0;
            busy_d = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (divcnt_q == div_q) begin
            if (bitcnt_q == BW'(DW - 1)) begin
              state_d = ST_DONE;
              dout_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              shreg_d  = shnext_s;
              dout_d   = msb_q ? shnext_s[DW-1] : shnext_s[0];
              bitcnt_d = bitcnt_q + BW'(1);
              divcnt_d = {DIVW{1'b0}};
            end
          end else begin
            divcnt_d = divcnt_q + DIVW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          dout_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      state_q  <= ST_IDLE;
      shreg_q  <= {DW{1'b0}};
      msb_q    <= 1'b0;
      div_q    <= {DIVW{1'b0}};
      divcnt_q <= {DIVW{1'b0}};
      bitcnt_q <= {BW{1'b0}};
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      msb_q    <= msb_d;
      div_q    <= div_d;
      divcnt_q <= divcnt_d;
      bitcnt_q <= bitcnt_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
- Parametrised successor to the single-word serial transceiver.
- Accepts DW-bit words through a valid/ready handshake into a DEPTH-entry FIFO and serialises them one after another on Dout.
- Bit rate comes from an internal programmable divider; bit order (MSB- or LSB-first) is chosen per word.
- Sits between the result-sampling path and the serial output pin, on the same Clk domain as the controller.

Parameters:
DW, 32, data word width in bits (>=2)
DEPTH, 4, FIFO depth in words (power of 2, >=2)
DIVW, 8, width of bit-period divider control

Ports:
Clk  in  1  system clock
Reset  in  1  reset; Reset, asynchronous, active-high; clock Clk
InValid  in  1  word offered on InData
InReady  out  1  FIFO can accept a word (=!full)
InData  in  DW  word to transmit
MsbFirst  in  1  1: MSB-first, 0: LSB-first; latched at word pop
Div  in  DIVW  bit period = Div+1 Clk cycles; latched at word pop
Flush  in  1  synchronous: empty FIFO, abort current word
Dout  out  1  serial data, 0 when idle
TxBusy  out  1  high while a word is being shifted
TxDone  out  1  one-cycle pulse after the last bit of each word
Level  out  $clog2(DEPTH)+1  words currently stored in FIFO

Behaviour:
- Reset values: Dout=0, TxBusy=0, TxDone=0, Level=0, InReady=1. FIFO pointers, shift register, bit and divider counters cleared. FSM goes to IDLE.
- Reset mid-word aborts immediately; no TxDone is generated.
- Push: on a Clk edge with InValid && InReady, InData is written at the write pointer and Level increments.
- InReady depends only on full; a pop in the same cycle does not free a slot for that cycle's push.
- Pointers wrap modulo DEPTH; Level is updated correctly on simultaneous push and pop.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if FIFO is non-empty, on the next edge:
  - pop the head word into the shift register;
  - latch MsbFirst and Div;
  - drive Dout with the first bit (bit DW-1 if MsbFirst, else bit 0);
  - set bitcnt=0, divcnt=0, TxBusy=1; go to SHIFT.
- Latency: word pushed into an empty FIFO at edge k appears as first bit on Dout after edge k+1.
- SHIFT: divcnt counts 0..Div_latched, so each bit is held exactly Div+1 cycles.
  - When divcnt==Div_latched and bitcnt<DW-1: output the next bit, bitcnt++, divcnt=0.
  - When divcnt==Div_latched and bitcnt==DW-1: go to DONE with Dout=0, TxBusy=0, TxDone=1.
- DONE: lasts one cycle. TxDone returns to 0 on exit; go to IDLE.
- Minimum gap between consecutive words is 2 cycles of Dout=0 (DONE, then IDLE pop).
- Changes to MsbFirst or Div while a word is in flight have no effect until the next pop.
- Div=0 gives one bit per Clk cycle. Div=all-ones gives 2^DIVW cycles per bit.
- Flush (priority over push and pop in the same cycle):
  - next edge sets pointers and Level=0;
  - FSM goes to IDLE with Dout=0, TxBusy=0;
  - no TxDone is generated;
  - a concurrent InValid is dropped.
- Empty FIFO in IDLE: Dout holds 0 and nothing is popped.
- Full FIFO: InReady=0, and InData is ignored even if InValid=1.
- All outputs are registered except InReady and Level, which are decoded from the registered pointers.

Test Plan:
- DW=32, Div=0, MsbFirst=1, push 0xA5000001 into empty FIFO at edge k -> Dout bits 1,0,1,0,0,1,0,1,0...0,1 on edges k+1..k+32, TxBusy high 32 cycles, TxDone pulse for 1 cycle after, Level returns to 0.
- Same word with MsbFirst=0, Div=2 -> LSB-first sequence 1,0,0,...; each bit held exactly 3 cycles (96 cycles total), then one TxDone pulse.
- Push 5 words back-to-back with DEPTH=4 while Div=3 -> InReady falls when Level=4. The 5th word is accepted only after the first pop. All 5 words are serialised in order with 2 idle-0 cycles between them and 5 TxDone pulses.
- Mid-word (bit 10 of word 1, two words queued): assert Flush for one cycle -> Dout=0, TxBusy=0 next cycle, Level=0, no TxDone, no further output.
- Assert Reset asynchronously mid-SHIFT -> all outputs at reset values immediately, without waiting for Clk. After release, a new push transmits correctly from bit 0.
- Toggle Div and MsbFirst during transmission of word 1 -> word 1 is unaffected; word 2 uses the new settings.
